// File: rtl/imem_loader.sv
// imem_loader: writes a streamed program image into instruction memory.
// Frame: LEN (4 bytes LE), LEN data words (LE), XOR checksum word.
// Holds the core in reset (core_hold) until the image loads and verifies.
// Ports: clk, reset (async, active-low), start, byte_valid/byte_data/byte_ready,
// imem_we/imem_addr/imem_wdata, core_hold, busy, done, err.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] len_q, len_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] csum_q, csum_d;
  logic        byte_ready_q, byte_ready_d;
  logic        imem_we_q, imem_we_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic        core_hold_q, core_hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        last_byte;
  logic [31:0] word_next;

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    len_d        = len_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    accept    = byte_valid && byte_ready_q;
    last_byte = accept && (bcnt_q == 2'd3);
    // Bytes shift in from the top so the first byte lands in [7:0].
    word_next = {byte_data, shift_q[31:8]};

    if (accept) begin
      shift_d = word_next;
      bcnt_d  = bcnt_q + 2'd1;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR;
          idx_d   = '0;
          csum_d  = '0;
          bcnt_d  = '0;
        end
      end
      ST_HDR: begin
        if (last_byte) begin
          len_d = word_next;
          if (word_next == '0 || word_next > 32'(MAX_WORDS)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (last_byte) begin
          // Write address/data are loaded on entry so they are registered in WRITE.
          state_d      = ST_WRITE;
          imem_addr_d  = BASE_ADDR + {idx_q[29:0], 2'b00};
          imem_wdata_d = word_next;
        end
      end
      ST_WRITE: begin
        csum_d = csum_q ^ imem_wdata_q;
        idx_d  = idx_q + 32'd1;
        if (idx_q + 32'd1 == len_q) begin
          state_d = ST_CSUM;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (last_byte) begin
          state_d = (word_next == csum_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they track state_q exactly.
    byte_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
    imem_we_d    = (state_d == ST_WRITE);
    busy_d       = (state_d == ST_HDR) || (state_d == ST_DATA) ||
                   (state_d == ST_WRITE) || (state_d == ST_CSUM);
    done_d       = (state_d == ST_DONE);
    err_d        = (state_d == ST_ERR);
    core_hold_d  = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bcnt_q       <= '0;
      shift_q      <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 64;

  logic        clk;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [63:0] sb[$];
  logic [31:0] img[$];
  logic [31:0] mem [0:MAXW-1];

  imem_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe pops one expected (addr, data) pair.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      check("rdy_in_write", {63'd0, byte_ready}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_we", {32'd0, imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("imem_write", {imem_addr, imem_wdata}, e);
        if (imem_addr[31:2] < MAXW) mem[imem_addr[31:2]] = imem_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        tick();
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      n++;
      if (n > 50) begin
        check("ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int unsigned i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], gaps);
    end
  endtask

  // Sends header, every word of img (pushing its expected write), then csum.
  task automatic send_frame(input logic [31:0] len, input logic [31:0] csum, input bit gaps);
    pulse_start();
    send_word(len, gaps);
    for (int unsigned i = 0; i < img.size(); i++) begin
      sb.push_back({BASE + 32'(4 * i), img[i]});
      send_word(img[i], gaps);
    end
    send_word(csum, gaps);
  endtask

  // Status must be final in the cycle right after the last accepted byte.
  task automatic expect_end(input string tag, input bit exp_done);
    @(negedge clk);
    check({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
    check({tag, "_err"}, {63'd0, err}, {63'd0, !exp_done});
    check({tag, "_hold"}, {63'd0, core_hold}, {63'd0, !exp_done});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
    tick();
  endtask

  function automatic logic [31:0] xor_img();
    logic [31:0] x;
    x = '0;
    foreach (img[i]) x ^= img[i];
    return x;
  endfunction

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // 1. Reset held: inputs toggle, outputs stay at reset values.
    for (int unsigned i = 0; i < 6; i++) begin
      byte_valid = i[0];
      start      = ~i[0];
      byte_data  = 8'(i);
      @(negedge clk);
      check("rst_flags", {58'd0, byte_ready, imem_we, core_hold, busy, done, err},
            {58'd0, 6'b001000});
      check("rst_bus", {imem_addr, imem_wdata}, 64'd0);
    end
    start      = 1'b0;
    byte_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("idle_flags", {58'd0, byte_ready, imem_we, core_hold, busy, done, err},
          {58'd0, 6'b001000});
    tick();

    // 2. Good load, LEN=2.
    img = '{32'h0050_0113, 32'h00C0_0193};
    send_frame(32'd2, 32'h0090_0080, 1'b0);
    expect_end("good", 1'b1);

    // 3. Bad checksum.
    send_frame(32'd2, 32'h0090_0081, 1'b0);
    expect_end("badcsum", 1'b0);

    // 4. Length rejection (0 and MAX+1), then a valid frame.
    img = '{};
    pulse_start();
    check("hdr_busy", {63'd0, busy}, 64'd1);
    send_word(32'd0, 1'b0);
    expect_end("len0", 1'b0);
    pulse_start();
    send_word(32'd65, 1'b0);
    expect_end("len65", 1'b0);
    img = '{32'h0050_0113, 32'h00C0_0193};
    send_frame(32'd2, xor_img(), 1'b0);
    expect_end("after_rej", 1'b1);

    // Boundary: exactly MAX_WORDS words are accepted.
    img = '{};
    for (int unsigned i = 0; i < MAXW; i++) img.push_back($urandom());
    send_frame(32'(MAXW), xor_img(), 1'b0);
    expect_end("maxlen", 1'b1);

    // 5. Random gaps; valid is held across each WRITE cycle.
    img = '{32'h0050_0113, 32'h00C0_0193};
    mem[0] = '0;
    mem[1] = '0;
    send_frame(32'd2, 32'h0090_0080, 1'b1);
    expect_end("gaps", 1'b1);
    check("gaps_mem0", {32'd0, mem[0]}, 64'h0050_0113);
    check("gaps_mem1", {32'd0, mem[1]}, 64'h00C0_0193);

    // 6. Reset mid-DATA after one word, then full reload and restart from DONE.
    pulse_start();
    sb.push_back({BASE, 32'h0050_0113});
    send_word(32'd2, 1'b0);
    send_word(32'h0050_0113, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h01, 1'b0);
    check("mid_sb_left", 64'(sb.size()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_flags", {58'd0, byte_ready, imem_we, core_hold, busy, done, err},
          {58'd0, 6'b001000});
    tick();
    reset = 1'b1;
    tick();
    send_frame(32'd2, 32'h0090_0080, 1'b0);
    expect_end("reload", 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_hold", {63'd0, core_hold}, 64'd1);
    check("restart_busy", {63'd0, busy}, 64'd1);
    check("restart_done", {63'd0, done}, 64'd0);
    repeat (3) tick();
    check("final_sb_left", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface; the core's fetch path is the reader.
- Receives a program image as a byte stream (valid/ready), assembles little-endian 32-bit words and writes them into instruction memory.
- Holds the core in reset until the image is loaded and its checksum verifies, then releases it.
- Sits beside the processor top, between a byte source (UART/debug link) and the instruction memory write port.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
MAX_WORDS, 64, instruction memory depth in words; larger images are rejected.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
byte_valid  input  1  byte_data holds a valid byte.
byte_data  input  8  stream byte.
byte_ready  output  1  loader accepts a byte this cycle.
imem_we  output  1  instruction memory write strobe, one cycle per word.
imem_addr  output  32  instruction memory write byte address.
imem_wdata  output  32  instruction word to write.
core_hold  output  1  1 = hold the core in reset.
busy  output  1  1 in HDR, DATA, WRITE or CSUM.
done  output  1  1 in DONE.
err  output  1  1 in ERR.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all counters and the checksum cleared. byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, busy=0, done=0, err=0.
- Byte transfer: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_ready is a function of state only: 1 in HDR, DATA and CSUM; 0 otherwise. No combinational path from byte_valid to byte_ready.
- Byte order: every 4 accepted bytes form one little-endian word; the first byte is bits [7:0]. A 2-bit byte counter wraps 3->0.
- Frame format: a 4-byte word count LEN, then LEN data words, then one 4-byte checksum word. Checksum = XOR of all data words, seeded 0.
- IDLE:
  - start -> HDR. Word index, checksum and byte counter are cleared; core_hold=1.
- HDR (4 bytes):
  - After the 4th byte: if LEN==0 or LEN>MAX_WORDS -> ERR, with no memory write.
  - Otherwise -> DATA.
- DATA:
  - After the 4th byte of a word -> WRITE.
- WRITE (exactly 1 cycle):
  - imem_we=1, imem_addr=BASE_ADDR+4*idx, imem_wdata=assembled word, byte_ready=0.
  - The word is XORed into the checksum and idx is incremented.
  - If idx+1==LEN -> CSUM; else -> DATA.
  - imem_addr and imem_wdata hold their last values when imem_we=0.
- CSUM (4 bytes):
  - After the 4th byte: received word == running XOR -> DONE; else -> ERR.
- DONE: core_hold=0, done=1. start -> HDR, with core_hold reasserted to 1 on the following cycle.
- ERR: core_hold=1, err=1. Stays in ERR until start.
- start pulses are ignored in HDR, DATA, WRITE and CSUM.
- A data byte offered during WRITE is not consumed; the source must hold it until byte_ready=1.
- All outputs are registered or decoded from registered state; they are glitch-free with respect to inputs.
- Reset mid-load: immediate return to IDLE with core_hold=1. Words already written stay in memory. The next load restarts from the header.
- Widths: idx and LEN compare as 32-bit unsigned. The imem_addr computation wraps modulo 2^32; it cannot overflow for legal LEN.
- Latency: the last byte of a word is accepted on edge N; imem_we is high in cycle N+1. The last checksum byte is accepted on edge M; done or err is high from cycle M+1.

Test Plan:
1. Reset check: hold reset=0, toggle byte_valid and start -> byte_ready=0, imem_we=0, core_hold=1, busy=done=err=0 throughout.
2. Good load, LEN=2:
   - Stream 02 00 00 00 | 13 01 50 00 | 93 01 C0 00 | 80 00 90 00.
   - Required: imem_we pulses with (addr 0x0, 0x00500113) then (addr 0x4, 0x00C00193).
   - Then done=1, core_hold=0, err=0.
3. Bad checksum: same stream with the checksum sent as 81 00 90 00 -> both writes occur, then err=1, core_hold=1, done=0.
4. Length rejection:
   - LEN=0 -> err=1 after the 4th header byte, with no imem_we.
   - Repeat with LEN=65 (MAX_WORDS=64) -> same result.
   - Then pulse start and send a valid frame -> done=1.
5. Backpressure and gaps:
   - Insert random byte_valid=0 gaps and hold byte_valid=1 across each WRITE cycle.
   - Required: byte_ready=0 during every WRITE cycle, no byte lost or duplicated, and memory contents match case 2.
6. Reset and restart:
   - Assert reset mid-DATA after 1 word is written -> IDLE, core_hold=1.
   - Full reload, then start in DONE -> core_hold=1 the next cycle and busy=1.
